// File: rtl/pkt_merger_pkg.sv
// Shared encodings for the packet merger: FSM states and arbitration grants.
package pkt_merger_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_DATA = 2'd1,
    SEND_CTRL = 2'd2
  } state_e;

  typedef enum logic {
    GNT_DATA = 1'b0,
    GNT_CTRL = 1'b1
  } grant_e;

endpackage

// File: rtl/pkt_merger_ctrl_fifo.sv
// Store-and-forward control FIFO. Writes advance a speculative pointer; only
// a tlast write commits the packet. A packet that hits full is rewound and
// the rest of it is swallowed, so a reader never sees a partial packet.
module pkt_merger_ctrl_fifo #(
  parameter int W  = 417,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic [W-1:0] din,
  input  logic         wr_en,
  input  logic         wr_last,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         pkt_avail,
  output logic         drop_pulse
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic         drop_q, drop_d, wr_fire;

  // Occupancy counts speculative beats too; the extra pointer bit resolves wrap.
  assign full      = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH));
  assign pkt_avail = (cmt_ptr_q != rd_ptr_q);
  assign dout      = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: write/commit/rewind/discard and read-out.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cmt_ptr_d  = cmt_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_d     = drop_q;
    drop_pulse = 1'b0;
    wr_fire    = 1'b0;
    if (wr_en) begin
      if (drop_q) begin
        if (wr_last) drop_d = 1'b0;
      end else if (full) begin
        wr_ptr_d   = cmt_ptr_q;
        drop_d     = !wr_last;
        drop_pulse = 1'b1;
      end else begin
        wr_fire  = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_last) cmt_ptr_d = wr_ptr_q + 1'b1;
      end
    end
    if (rd_en && pkt_avail) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer and drop-mode registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      drop_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      drop_q    <= drop_d;
    end
  end

  // Storage; contents are only meaningful behind the committed pointer.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pkt_merger.sv
// Merges the backpressured data stream and the buffered control stream onto
// one registered AXI-Stream master, whole packets at a time, round-robin.
module pkt_merger
  import pkt_merger_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CTRL_FIFO_DEPTH_BITS = 4
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
  input  logic                              ctrl_s_axis_tvalid,
  input  logic                              ctrl_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [15:0]                       ctrl_drop_cnt
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int BW = DW + KW + UW + 1;  // {tdata, tkeep, tuser, tlast}

  state_e          state_q, state_d;
  grant_e          grant_q, grant_d;
  logic [DW-1:0]   m_tdata_q;
  logic [KW-1:0]   m_tkeep_q;
  logic [UW-1:0]   m_tuser_q;
  logic            m_tvalid_q, m_tlast_q;
  logic [15:0]     drop_cnt_q;
  logic [BW-1:0]   fifo_dout, ld_beat;
  logic            fifo_rd, ctrl_avail, drop_pulse, ld, free;

  pkt_merger_ctrl_fifo #(.W(BW), .AW(CTRL_FIFO_DEPTH_BITS)) u_ctrl_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .din       ({ctrl_s_axis_tdata, ctrl_s_axis_tkeep, ctrl_s_axis_tuser, ctrl_s_axis_tlast}),
    .wr_en     (ctrl_s_axis_tvalid),
    .wr_last   (ctrl_s_axis_tlast),
    .rd_en     (fifo_rd),
    .dout      (fifo_dout),
    .full      (),
    .pkt_avail (ctrl_avail),
    .drop_pulse(drop_pulse)
  );

  assign free          = !m_tvalid_q || m_axis_tready;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign ctrl_drop_cnt = drop_cnt_q;

  // Arbitration and packet transfer; one source owns the output until tlast.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    s_axis_tready = 1'b0;
    fifo_rd       = 1'b0;
    ld            = 1'b0;
    ld_beat       = '0;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid && ctrl_avail) begin
          if (grant_q == GNT_DATA) begin
            state_d = SEND_CTRL; grant_d = GNT_CTRL;
          end else begin
            state_d = SEND_DATA; grant_d = GNT_DATA;
          end
        end else if (s_axis_tvalid) begin
          state_d = SEND_DATA; grant_d = GNT_DATA;
        end else if (ctrl_avail) begin
          state_d = SEND_CTRL; grant_d = GNT_CTRL;
        end
      end
      SEND_DATA: begin
        s_axis_tready = free;
        if (s_axis_tvalid && free) begin
          ld      = 1'b1;
          ld_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
          if (s_axis_tlast) state_d = IDLE;
        end
      end
      SEND_CTRL: begin
        // The whole packet is committed, so ctrl_avail holds until its tlast.
        if (free && ctrl_avail) begin
          fifo_rd = 1'b1;
          ld      = 1'b1;
          ld_beat = fifo_dout;
          if (fifo_dout[0]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and round-robin memory.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= GNT_DATA;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Output register: reload on a free cycle, otherwise hold everything.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
    end else if (free) begin
      m_tvalid_q <= ld;
      if (ld) {m_tdata_q, m_tkeep_q, m_tuser_q, m_tlast_q} <= ld_beat;
    end
  end

  // Saturating count of dropped control packets.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                             drop_cnt_q <= '0;
    else if (drop_pulse && drop_cnt_q != '1)  drop_cnt_q <= drop_cnt_q + 16'd1;
  end

endmodule

// File: tb/tb_pkt_merger.sv
// Directed scenarios with random payloads for pkt_merger. Expected streams
// are built from packet-level rules (round-robin order, FIFO capacity).
module tb_pkt_merger;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [255:0] s_axis_tdata, ctrl_s_axis_tdata, m_axis_tdata;
  logic [31:0]  s_axis_tkeep, ctrl_s_axis_tkeep, m_axis_tkeep;
  logic [127:0] s_axis_tuser, ctrl_s_axis_tuser, m_axis_tuser;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic         ctrl_s_axis_tvalid, ctrl_s_axis_tlast;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [15:0]  ctrl_drop_cnt;

  pkt_merger dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .ctrl_s_axis_tdata(ctrl_s_axis_tdata), .ctrl_s_axis_tkeep(ctrl_s_axis_tkeep),
    .ctrl_s_axis_tuser(ctrl_s_axis_tuser), .ctrl_s_axis_tvalid(ctrl_s_axis_tvalid),
    .ctrl_s_axis_tlast(ctrl_s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .ctrl_drop_cnt(ctrl_drop_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0, failures = 0, exp_drops = 0;
  beat_t dq[$], cq[$], exp_q[$], out_q[$], pk[$], p1[$], p2[$];
  int    out_cyc[$];
  beat_t cur, prev;
  bit    prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rnd_beat(input bit last);
    beat_t b;
    for (int i = 0; i < 8; i++) b.d[i*32 +: 32] = $urandom;
    b.k = $urandom;
    for (int i = 0; i < 4; i++) b.u[i*32 +: 32] = $urandom;
    b.l = last;
    return b;
  endfunction

  task automatic gen(input int len);
    pk.delete();
    for (int i = 0; i < len; i++) pk.push_back(rnd_beat(i == len - 1));
  endtask

  // Cycle loop: drive both sources, monitor the master side, check holds.
  // rmode 0 = ready, 1 = stalled, 2 = toggling. Stops 'tail' cycles after
  // 'want' beats were seen (want=0: runs max_cyc cycles).
  task automatic run(input int cstart, input int rmode, input int max_cyc,
                     input int want, input int tail);
    int extra = -1;
    out_q.delete(); out_cyc.delete();
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      s_axis_tvalid = (dq.size() > 0);
      if (dq.size() > 0) {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = dq[0];
      ctrl_s_axis_tvalid = (cyc >= cstart) && (cq.size() > 0);
      if (cq.size() > 0)
        {ctrl_s_axis_tdata, ctrl_s_axis_tkeep, ctrl_s_axis_tuser, ctrl_s_axis_tlast} = cq[0];
      m_axis_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : (cyc % 2 == 0);
      @(negedge clk);
      cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
      if (prev_stall) chk("hold", {m_axis_tvalid, cur}, {1'b1, prev});
      if (m_axis_tvalid && m_axis_tready) begin
        out_q.push_back(cur);
        out_cyc.push_back(cyc);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev = cur;
      if (s_axis_tvalid && s_axis_tready) void'(dq.pop_front());
      if (ctrl_s_axis_tvalid) void'(cq.pop_front());
      @(posedge clk); #1;
      if (extra < 0 && want > 0 && out_q.size() >= want) extra = tail;
      if (extra == 0) break;
      if (extra > 0) extra--;
    end
    s_axis_tvalid = 1'b0;
    ctrl_s_axis_tvalid = 1'b0;
    if (want > 0) chk("timeout", (extra >= 0), 1'b1);
  endtask

  task automatic check_out(input string tag);
    chk({tag, " count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s beat%0d", tag, i), out_q[i], exp_q[i]);
  endtask

  // Two control packets while the output is stalled. A packet fits if its
  // beats plus everything already buffered fit the 16 entries; at most one
  // beat of the first packet can leave into the stalled output register.
  task automatic overflow(input int len1, input int len2, input string tag);
    int occ = 0;
    gen(len1); p1 = pk;
    gen(len2); p2 = pk;
    cq = p1; foreach (p2[i]) cq.push_back(p2[i]);
    exp_q.delete();
    occ = len1;
    foreach (p1[i]) exp_q.push_back(p1[i]);
    if (occ + len2 <= 16) foreach (p2[i]) exp_q.push_back(p2[i]);
    else exp_drops++;
    run(0, 1, 45, 0, 0);
    chk({tag, " stalled beats"}, out_q.size(), 0);
    chk({tag, " drop_cnt"}, ctrl_drop_cnt, exp_drops[15:0]);
    run(0, 0, 120, exp_q.size(), 6);
    check_out(tag);
    chk({tag, " drop_cnt after"}, ctrl_drop_cnt, exp_drops[15:0]);
  endtask

  initial begin
    int l1, l2;
    aresetn = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;
    ctrl_s_axis_tvalid = 1'b0; ctrl_s_axis_tdata = '0; ctrl_s_axis_tkeep = '0;
    ctrl_s_axis_tuser = '0; ctrl_s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst m_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, '0);
    chk("rst s_tready", s_axis_tready, 1'b0);
    chk("rst drop_cnt", ctrl_drop_cnt, 16'd0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Data only, 3 beats: first output two cycles after tvalid.
    gen(3); dq = pk; exp_q = pk; cq.delete();
    run(0, 0, 40, 3, 6);
    check_out("data");
    if (out_cyc.size() == 3) begin
      chk("data lat first", out_cyc[0], 2);
      chk("data lat last", out_cyc[2], 4);
    end

    // Control only, 2 beats: output three cycles after the tlast write.
    gen(2); pk[0].d[64 +: 16] = 16'hF2F1; pk[1].d[64 +: 16] = 16'hF2F1;
    cq = pk; exp_q = pk;
    run(0, 0, 40, 2, 6);
    check_out("ctrl");
    if (out_cyc.size() == 2) chk("ctrl lat", out_cyc[0], 4);
    chk("ctrl drop_cnt", ctrl_drop_cnt, 16'd0);

    // Contention: ctrl commits during data packet 1 -> d1, ctrl, d2, d3.
    begin
      beat_t d1[$], d2[$], d3[$], c[$];
      gen(4); d1 = pk; gen(4); d2 = pk; gen(4); d3 = pk; gen(2); c = pk;
      dq = d1; foreach (d2[i]) dq.push_back(d2[i]); foreach (d3[i]) dq.push_back(d3[i]);
      cq = c;
      exp_q = d1; foreach (c[i]) exp_q.push_back(c[i]);
      foreach (d2[i]) exp_q.push_back(d2[i]); foreach (d3[i]) exp_q.push_back(d3[i]);
      run(1, 0, 80, 14, 6);
      check_out("contend");
    end

    // Overflow: directed 10/10, then a random pair away from the edge case.
    overflow(10, 10, "ovf");
    l1 = $urandom_range(6, 12);
    l2 = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 16 - l1) : $urandom_range(18 - l1, 21 - l1);
    overflow(l1, l2, "ovf_rnd");

    // Backpressure: ready toggles each cycle over a 5-beat data packet.
    gen(5); dq = pk; exp_q = pk; cq.delete();
    run(0, 2, 60, 5, 6);
    check_out("bp");

    // Reset during control readout, then a clean data packet.
    gen(4); cq = pk; exp_q = pk;
    run(0, 0, 40, 2, 0);
    aresetn = 1'b0;
    #1;
    chk("midrst m_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst drop_cnt", ctrl_drop_cnt, 16'd0);
    chk("midrst s_tready", s_axis_tready, 1'b0);
    exp_drops = 0;
    prev_stall = 1'b0;
    #3 aresetn = 1'b1;
    @(posedge clk); #1;
    cq.delete();
    gen(3); dq = pk; exp_q = pk;
    run(0, 0, 40, 3, 8);
    check_out("post_rst");
    chk("post_rst drop_cnt", ctrl_drop_cnt, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_merger.md
Name: pkt_merger

Overview:
- Egress-side counterpart of the ingress data/control split.
- Merges two AXI-Stream sources onto one master stream:
  - data-path packets arriving with backpressure;
  - control-response packets arriving on a no-backpressure control stream.
- Control packets are buffered store-and-forward in an internal FIFO; arbitration is whole-packet round-robin.
- Sits between the pipeline tail and the egress MAC/DMA interface.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width; tkeep width = C_S_AXIS_DATA_WIDTH/8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- CTRL_FIFO_DEPTH_BITS, 4, control FIFO depth = 2^N beats.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  data-path input.
- s_axis_tready  out  1  data-path ready.
- ctrl_s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  control input; no tready, a beat is accepted whenever tvalid=1.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  merged output, registered.
- m_axis_tready  in  1  downstream ready.
- ctrl_drop_cnt  out  16  control packets dropped, saturating at 16'hFFFF.

Behaviour:
Clocking and reset
- One clock, clk. Reset aresetn is asynchronous, active-low.
- Reset values: all m_axis_* = 0, s_axis_tready = 0, ctrl_drop_cnt = 0, state = IDLE, last_grant = DATA, FIFO empty.
- Reset mid-operation discards the partial packet and all FIFO contents. Upstream sources are reset together with this block, so no packet tails arrive after reset.

Output register
- Loads a new beat when (!m_axis_tvalid || m_axis_tready); otherwise holds all m_axis_* stable.
- m_axis_tvalid drops to 0 only when no beat is loaded on a free cycle.

Control FIFO (sub-module)
- Write pointer is speculative; a separate committed pointer advances only on a tlast write.
- Write to a full FIFO mid-packet:
  - rewind the speculative pointer to the committed pointer;
  - discard the rest of that packet up to and including tlast;
  - increment ctrl_drop_cnt once per dropped packet.
- ctrl_pkt_avail = (committed pointer != read pointer).
- A packet longer than 2^N beats is always dropped.
- Simultaneous commit and read-out of a different packet is legal; pointers wrap modulo 2^N with an extra wrap bit.

State machine (IDLE, SEND_DATA, SEND_CTRL)
- IDLE, both sources pending: grant the source opposite to last_grant.
- IDLE, one source pending: grant that source.
  - Data pending = s_axis_tvalid.
  - Control pending = ctrl_pkt_avail.
- The grant registers the state and last_grant. s_axis_tready = 0 in IDLE.
- SEND_DATA:
  - s_axis_tready = (!m_axis_tvalid || m_axis_tready);
  - each accepted beat is loaded into the output register;
  - an accepted beat with tlast=1 returns to IDLE.
- SEND_CTRL:
  - FIFO read on each free output cycle;
  - the beat read with tlast=1 returns to IDLE.
- Packets are never interleaved. tuser, tkeep and tlast pass through unchanged.

Latency (output free)
- Data: s_axis_tvalid first seen in IDLE at cycle T → tready at T+1 → m_axis_tvalid at T+2. Subsequent beats stream one per cycle.
- Control: tlast written at T → ctrl_pkt_avail at T+1 → grant → first beat on m_axis at T+3.
- IDLE inserts one bubble cycle between packets.

Boundaries
- m_axis_tready held low: both inputs stall, except the control FIFO, which keeps accepting until full and then drops.
- Control writes continue in every state.

Decomposition:
- Shared header/package: state encodings (IDLE=0, SEND_DATA=1, SEND_CTRL=2) and grant encodings (DATA=0, CTRL=1).
- One sub-module, pkt_merger_ctrl_fifo: commit/rewind FIFO with ports din, wr_en, wr_last, rd_en, dout, full, pkt_avail, drop_pulse, plus clk and aresetn.

Test Plan:
- Data only: 3-beat packet, m_axis_tready=1 → beats 0,1,2 appear on m_axis at T+2..T+4; tlast on beat 2; tdata/tkeep/tuser bit-exact.
- Control only: 2-beat packet with tdata[64+:16]=16'hF2F1 → output starts 3 cycles after the ctrl tlast; 2 beats bit-exact; ctrl_drop_cnt=0.
- Contention: continuous 4-beat data packets plus one 2-beat control packet committed during data packet 1 → output order data1, ctrl, data2; no interleave.
- Overflow: CTRL_FIFO_DEPTH_BITS=4, m_axis_tready=0, control packets of 10 then 10 beats → first stored, second dropped; ctrl_drop_cnt=1; after tready=1 only the first packet (10 beats) emerges.
- Backpressure: toggle m_axis_tready 1,0,1,0 during a 5-beat data packet → m_axis_* held stable while tready=0; 5 beats delivered, no loss or duplication.
- Reset mid-packet: deassert aresetn during beat 2 of a control readout → m_axis_tvalid=0 immediately; ctrl_drop_cnt=0; FIFO empty; the next data packet passes normally.
